// File: rtl/wb_writeback_stage.sv
// rtl/wb_writeback_stage.sv - MEM/WB holding register, load align/extend and write-back select
module wb_writeback_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  localparam int OFS_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [OFS_W-1:0] in_addr_lo,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_pcimm,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_FULL, S_WAIT} state_t;

  state_t state, state_nxt;

  logic             e_reg_write;
  logic [RA_W-1:0]  e_rd;
  logic [1:0]       e_wb_sel;
  logic [2:0]       e_funct3;
  logic [OFS_W-1:0] e_addr_lo;
  logic [XLEN-1:0]  e_alu, e_pc4, e_pcimm;

  logic            load_wait, accept, retire;
  logic [XLEN-1:0] shifted, load_val, src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_reg_write <= 1'b0;
      e_rd        <= '0;
      e_wb_sel    <= '0;
      e_funct3    <= '0;
      e_addr_lo   <= '0;
      e_alu       <= '0;
      e_pc4       <= '0;
      e_pcimm     <= '0;
    end else if (accept) begin
      e_reg_write <= in_reg_write;
      e_rd        <= in_rd;
      e_wb_sel    <= in_wb_sel;
      e_funct3    <= in_funct3;
      e_addr_lo   <= in_addr_lo;
      e_alu       <= in_alu;
      e_pc4       <= in_pc4;
      e_pcimm     <= in_pcimm;
    end
  end

  // A load entry that still lacks data is the only thing that stalls MEM.
  always_comb begin
    load_wait = (state == S_WAIT) && !mem_rvalid;
    in_ready  = !load_wait;
    accept    = in_valid && !load_wait;
    retire    = (state == S_FULL) || ((state == S_WAIT) && mem_rvalid);
    busy      = (state == S_WAIT);
    state_nxt = S_IDLE;
    if (accept)         state_nxt = (in_wb_sel == 2'b01) ? S_WAIT : S_FULL;
    else if (load_wait) state_nxt = S_WAIT;
  end

  // Codes without a meaning at this XLEN write the raw word unshifted.
  always_comb begin
    shifted = mem_rdata >> {e_addr_lo, 3'b000};
    case (e_funct3)
      3'b000:  load_val = XLEN'($signed(shifted[7:0]));
      3'b001:  load_val = XLEN'($signed(shifted[15:0]));
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      3'b010:  load_val = XLEN'($signed(shifted[31:0]));
      3'b110:  load_val = (XLEN == 64) ? XLEN'(shifted[31:0]) : mem_rdata;
      3'b011:  load_val = (XLEN == 64) ? shifted : mem_rdata;
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    case (e_wb_sel)
      2'b00:   src = e_alu;
      2'b01:   src = load_val;
      2'b10:   src = e_pc4;
      default: src = e_pcimm;
    endcase
    rf_we     = retire && e_reg_write && (e_rd != '0);
    rf_waddr  = rf_we ? e_rd : '0;
    rf_wdata  = rf_we ? src : '0;
    fwd_valid = rf_we;
    fwd_rd    = rf_waddr;
    fwd_data  = rf_wdata;
  end

endmodule

// File: tb/tb_wb_writeback_stage.sv
// tb/tb_wb_writeback_stage.sv - bench for wb_writeback_stage at XLEN 32 and 64
module tb_wb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_reg_write, mem_rvalid;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3, in_addr_lo;
  logic [63:0] in_alu, in_pc4, in_pcimm, mem_rdata;

  logic        r32_ready, r32_we, r32_fv, r32_busy;
  logic [4:0]  r32_waddr, r32_frd;
  logic [31:0] r32_wdata, r32_fdata;
  logic        r64_ready, r64_we, r64_fv, r64_busy;
  logic [4:0]  r64_waddr, r64_frd;
  logic [63:0] r64_wdata, r64_fdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_writeback_stage #(.XLEN(32), .RA_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo[1:0]), .in_alu(in_alu[31:0]),
    .in_pc4(in_pc4[31:0]), .in_pcimm(in_pcimm[31:0]), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .rf_we(r32_we), .rf_waddr(r32_waddr),
    .rf_wdata(r32_wdata), .fwd_valid(r32_fv), .fwd_rd(r32_frd),
    .fwd_data(r32_fdata), .busy(r32_busy)
  );

  wb_writeback_stage #(.XLEN(64), .RA_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu(in_alu),
    .in_pc4(in_pc4), .in_pcimm(in_pcimm), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_we(r64_we), .rf_waddr(r64_waddr),
    .rf_wdata(r64_wdata), .fwd_valid(r64_fv), .fwd_rd(r64_frd),
    .fwd_data(r64_fdata), .busy(r64_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: at most one pending instruction; a load is held until data shows up.
  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3, a;
    logic [63:0] alu, pc4, pcimm;
  } ent_t;

  logic m_has = 1'b0;
  logic m_wait;
  ent_t m_e;

  function automatic logic [63:0] msk(input int bits);
    return (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
  endfunction

  function automatic logic [63:0] m_load(input int xlen, input logic [2:0] f3,
                                         input logic [2:0] a, input logic [63:0] raw);
    logic [63:0] r, sh, v;
    int bits;
    bit sgn;
    r  = raw & msk(xlen);
    sh = r >> (8 * (a % (xlen / 8)));
    case (f3)
      3'd0: begin bits = 8;  sgn = 1; end
      3'd1: begin bits = 16; sgn = 1; end
      3'd4: begin bits = 8;  sgn = 0; end
      3'd5: begin bits = 16; sgn = 0; end
      3'd2: begin bits = 32; sgn = 1; end
      3'd6: begin if (xlen != 64) return r; bits = 32; sgn = 0; end
      3'd3: begin if (xlen != 64) return r; return sh; end
      default: return r;
    endcase
    v = sh & msk(bits);
    if (sgn && v[bits-1]) v = v | ~msk(bits);
    return v & msk(xlen);
  endfunction

  function automatic logic [63:0] m_src(input int xlen, input ent_t e, input logic [63:0] raw);
    case (e.sel)
      2'd0:    return e.alu & msk(xlen);
      2'd1:    return m_load(xlen, e.f3, e.a, raw);
      2'd2:    return e.pc4 & msk(xlen);
      default: return e.pcimm & msk(xlen);
    endcase
  endfunction

  task automatic model_check();
    logic we;
    logic [63:0] e32, e64;
    m_wait = m_has && (m_e.sel == 2'd1) && !mem_rvalid;
    we  = m_has && !m_wait && m_e.rw && (m_e.rd != 0);
    e32 = we ? m_src(32, m_e, mem_rdata) : 64'd0;
    e64 = we ? m_src(64, m_e, mem_rdata) : 64'd0;
    chk("m_ready32", r32_ready, !m_wait);
    chk("m_busy32",  r32_busy, m_has && (m_e.sel == 2'd1));
    chk("m_we32",    r32_we, we);
    chk("m_waddr32", r32_waddr, we ? m_e.rd : 5'd0);
    chk("m_wdata32", r32_wdata, e32);
    chk("m_fwd32",   {r32_fv, r32_frd, r32_fdata}, {we, (we ? m_e.rd : 5'd0), e32[31:0]});
    chk("m_ready64", r64_ready, !m_wait);
    chk("m_busy64",  r64_busy, m_has && (m_e.sel == 2'd1));
    chk("m_we64",    r64_we, we);
    chk("m_waddr64", r64_waddr, we ? m_e.rd : 5'd0);
    chk("m_wdata64", r64_wdata, e64);
    chk("m_fvrd64",  {r64_fv, r64_frd}, {we, (we ? m_e.rd : 5'd0)});
    chk("m_fdata64", r64_fdata, e64);
  endtask

  task automatic cycle();
    model_check();
    @(posedge clk);
    if (in_valid && !m_wait) begin
      m_has = 1'b1;
      m_e   = '{in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo, in_alu, in_pc4, in_pcimm};
    end else if (!m_wait) begin
      m_has = 1'b0;
    end
    #1;
  endtask

  typedef struct {
    logic        v, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3, a;
    logic [63:0] val;
    logic        rv;
    logic [63:0] rdata;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_d32, e_d64;
    logic        e_rdy, e_busy;
  } vec_t;

  vec_t tbl[20];

  task automatic idle_inputs();
    in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0; in_funct3 = 0;
    in_addr_lo = 0; in_alu = 0; in_pc4 = 0; in_pcimm = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    //          v rw rd sel f3 a  val      rv rdata                     we wa d32          d64                    rdy busy
    tbl[0]  = '{1, 1, 5, 0, 0, 0, 64'h1234, 0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   1, 5, 64'h1234,     64'h1234,              1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[3]  = '{1, 1, 7, 1, 0, 2, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 64'h0,    1, 64'h0080_0000,           1, 7, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1, 1};
    tbl[7]  = '{1, 1, 8, 1, 5, 2, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 0, 64'h11,   1, 64'hBEEF_0000,           1, 8, 64'hBEEF,     64'hBEEF,              1, 1};
    tbl[9]  = '{1, 1, 2, 2, 0, 0, 64'h104,  0, 64'h0,                   1, 1, 64'h11,       64'h11,                1, 0};
    tbl[10] = '{1, 1, 3, 3, 0, 0, 64'h2000, 0, 64'h0,                   1, 2, 64'h104,      64'h104,               1, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 0, 64'hDEAD, 0, 64'h0,                   1, 3, 64'h2000,     64'h2000,              1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[13] = '{1, 1, 9, 1, 6, 4, 64'h0,    1, 64'h8000_0001_1234_5678, 0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 64'h0,    1, 64'h8000_0001_1234_5678, 1, 9, 64'h1234_5678, 64'h0000_0000_8000_0001, 1, 1};
    tbl[15] = '{1, 1, 10, 1, 3, 0, 64'h0,   0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 64'h0,    1, 64'hFEDC_BA98_7654_3210, 1, 10, 64'h7654_3210, 64'hFEDC_BA98_7654_3210, 1, 1};
    tbl[17] = '{1, 1, 11, 1, 2, 4, 64'h0,   0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 64'h0,    1, 64'h8765_4321_0000_0000, 1, 11, 64'h0,       64'hFFFF_FFFF_8765_4321, 1, 1};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 64'h0,    0, 64'h0,                   0, 0, 64'h0,        64'h0,                 1, 0};

    rst = 1'b1;
    idle_inputs();
    #12;
    chk("rst_ready32", r32_ready, 1);
    chk("rst_ready64", r64_ready, 1);
    chk("rst_out32", {r32_we, r32_waddr, r32_wdata, r32_busy}, 0);
    chk("rst_out64", {r64_we, r64_waddr, r64_busy}, 0);
    chk("rst_wdata64", r64_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].v; in_reg_write = tbl[i].rw; in_rd = tbl[i].rd;
      in_wb_sel = tbl[i].sel; in_funct3 = tbl[i].f3; in_addr_lo = tbl[i].a;
      in_alu   = (tbl[i].sel == 0) ? tbl[i].val : 64'hA5A5;
      in_pc4   = (tbl[i].sel == 2) ? tbl[i].val : 64'hB6B6;
      in_pcimm = (tbl[i].sel == 3) ? tbl[i].val : 64'hC7C7;
      mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("tbl%0d_we32", i),    r32_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr32", i), r32_waddr, tbl[i].e_wa);
      chk($sformatf("tbl%0d_wdata32", i), r32_wdata, tbl[i].e_d32);
      chk($sformatf("tbl%0d_fwd32", i),   {r32_fv, r32_frd, r32_fdata}, {tbl[i].e_we, tbl[i].e_wa, tbl[i].e_d32[31:0]});
      chk($sformatf("tbl%0d_we64", i),    r64_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_wdata64", i), r64_wdata, tbl[i].e_d64);
      chk($sformatf("tbl%0d_ready", i),   {r32_ready, r64_ready}, {tbl[i].e_rdy, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_busy", i),    {r32_busy, r64_busy}, {tbl[i].e_busy, tbl[i].e_busy});
      cycle();
    end

    // Reset while a load is pending, then a late response must be dropped.
    idle_inputs();
    in_valid = 1; in_reg_write = 1; in_rd = 12; in_wb_sel = 1; in_funct3 = 0;
    #1; cycle();
    idle_inputs();
    #1;
    chk("wait_busy32", r32_busy, 1);
    cycle();
    rst = 1'b1;
    #1;
    m_has = 1'b0;
    chk("rstw_ready", {r32_ready, r64_ready}, 2'b11);
    chk("rstw_out32", {r32_we, r32_waddr, r32_wdata, r32_busy}, 0);
    chk("rstw_out64", {r64_we, r64_waddr, r64_busy, r64_fv}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("late_rvalid_we", {r32_we, r64_we}, 0);
    chk("late_rvalid_busy", {r32_busy, r64_busy}, 0);
    cycle();
    idle_inputs();
    #1; cycle();

    for (int i = 0; i < 1500; i++) begin
      in_valid     = ($urandom % 4) != 0;
      in_reg_write = ($urandom % 4) != 0;
      in_rd        = 5'($urandom % 8);
      in_wb_sel    = 2'($urandom);
      in_funct3    = 3'($urandom);
      in_addr_lo   = 3'($urandom);
      in_alu       = {$urandom, $urandom};
      in_pc4       = {$urandom, $urandom};
      in_pcimm     = {$urandom, $urandom};
      mem_rvalid   = ($urandom % 3) == 0;
      mem_rdata    = {$urandom, $urandom};
      #1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
